// File: rtl/mem_unit_pkg.sv
// Shared types and constants for the 8x8 NAND-latch memory unit
// and its sequencing front-end.
package mem_unit_pkg;

   localparam int MEM_ADDR_W = 3;
   localparam int MEM_DATA_W = 8;

   localparam logic OP_READ  = 1'b0;
   localparam logic OP_WRITE = 1'b1;

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      SETUP   = 3'd1,
      STROBE  = 3'd2,
      HOLD    = 3'd3,
      VSETUP  = 3'd4,
      VSTROBE = 3'd5,
      VHOLD   = 3'd6,
      RESP    = 3'd7
   } state_t;

endpackage

// File: rtl/mem_unit_ctrl.sv
// Setup/strobe/hold sequencer in front of the asynchronous latch array.
// MEM_UNIT_CTRL_READBACK_EN adds a verify read after every write.
module mem_unit_ctrl
   import mem_unit_pkg::*;
#(
   parameter int STROBE_CYCLES = 2,
   parameter int ADDR_W        = MEM_ADDR_W,
   parameter int DATA_W        = MEM_DATA_W
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_op,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic [DATA_W-1:0] req_wdata,
   output logic              rsp_valid,
   output logic [DATA_W-1:0] rsp_rdata,
   output logic              rsp_err,
   output logic              mem_op,
   output logic              mem_select,
   output logic [ADDR_W-1:0] mem_address,
   output logic [DATA_W-1:0] mem_in_bus,
   input  logic [DATA_W-1:0] mem_out_bus
);

   localparam int CNT_W = $clog2(STROBE_CYCLES + 1);
   localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(STROBE_CYCLES);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(1);

   state_t           state;
   logic [CNT_W-1:0] cnt;

`ifdef MEM_UNIT_CTRL_READBACK_EN
   logic err_q;
   assign rsp_err = err_q;
`else
   assign rsp_err = 1'b0;
`endif

   // ready is decoded from state so a held reset never accepts
   assign req_ready = (state == IDLE) && !rst;

   // access sequencer: all memory-side and response outputs registered
   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= IDLE;
         cnt         <= '0;
         rsp_valid   <= 1'b0;
         rsp_rdata   <= '0;
         mem_op      <= OP_READ;
         mem_select  <= 1'b0;
         mem_address <= '0;
         mem_in_bus  <= '0;
`ifdef MEM_UNIT_CTRL_READBACK_EN
         err_q       <= 1'b0;
`endif
      end else begin
         unique case (state)
            IDLE: begin
               if (req_valid) begin
                  state       <= SETUP;
                  mem_op      <= req_op;
                  mem_address <= req_addr;
                  mem_in_bus  <= req_wdata;
               end
            end
            SETUP: begin
               state      <= STROBE;
               mem_select <= 1'b1;
               cnt        <= CNT_LOAD;
            end
            STROBE: begin
               if (cnt == CNT_LAST) begin
                  state      <= HOLD;
                  mem_select <= 1'b0;
                  if (mem_op == OP_READ)
                     rsp_rdata <= mem_out_bus;
               end else begin
                  cnt <= cnt - CNT_LAST;
               end
            end
            HOLD: begin
`ifdef MEM_UNIT_CTRL_READBACK_EN
               if (mem_op == OP_WRITE) begin
                  state  <= VSETUP;
                  mem_op <= OP_READ;
               end else begin
                  state     <= RESP;
                  rsp_valid <= 1'b1;
               end
`else
               state     <= RESP;
               rsp_valid <= 1'b1;
`endif
            end
`ifdef MEM_UNIT_CTRL_READBACK_EN
            VSETUP: begin
               state      <= VSTROBE;
               mem_select <= 1'b1;
               cnt        <= CNT_LOAD;
            end
            VSTROBE: begin
               if (cnt == CNT_LAST) begin
                  state      <= VHOLD;
                  mem_select <= 1'b0;
                  rsp_rdata  <= mem_out_bus;
                  err_q      <= (mem_out_bus != mem_in_bus);
               end else begin
                  cnt <= cnt - CNT_LAST;
               end
            end
            VHOLD: begin
               state     <= RESP;
               rsp_valid <= 1'b1;
            end
`endif
            RESP: begin
               state     <= IDLE;
               rsp_valid <= 1'b0;
               mem_op    <= OP_READ;
`ifdef MEM_UNIT_CTRL_READBACK_EN
               err_q     <= 1'b0;
`endif
            end
            default: begin
               state      <= IDLE;
               mem_select <= 1'b0;
               rsp_valid  <= 1'b0;
               mem_op     <= OP_READ;
            end
         endcase
      end
   end

endmodule
